// File: rtl/display_scan_sequencer.sv
// Scan-phase generator and scrolling 4-character window for a 4-digit multiplexed display.
// Characters come from a 16-entry circular message buffer; the window moves one slot every SCROLL_REFRESH frames.
module display_scan_sequencer #(
  parameter int unsigned PRESCALE       = 16,
  parameter int unsigned SCROLL_REFRESH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] msg_in,
  input  logic        scroll_en,
  output logic [3:0]  counter,
  output logic [3:0]  c0,
  output logic [3:0]  c1,
  output logic [3:0]  c2,
  output logic [3:0]  c3,
  output logic        frame_tick,
  output logic        scroll_tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned FW = (SCROLL_REFRESH > 1) ? $clog2(SCROLL_REFRESH) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [FW-1:0] FMAX = FW'(SCROLL_REFRESH - 1);

  logic [PW-1:0] r_presc;
  logic [3:0]    r_counter;
  logic [FW-1:0] r_frame_cnt;
  logic [3:0]    r_ptr;
  logic [63:0]   r_buf;
  logic [3:0]    r_c0, r_c1, r_c2, r_c3;
  logic          r_frame_tick;
  logic          r_scroll_tick;

  logic          w_step;
  logic          w_boundary;
  logic          w_scroll_due;
  logic [3:0]    w_ptr_nxt;
  logic [63:0]   w_src;

  function automatic logic [3:0] char_at(input logic [63:0] m, input logic [3:0] idx);
    return m[{idx, 2'b00} +: 4];
  endfunction

  always_comb begin
    w_step       = (r_presc == PMAX);
    w_boundary   = w_step && (r_counter == 4'hF);
    w_scroll_due = w_boundary && scroll_en && (r_frame_cnt == FMAX);
    // A load overrides the scroll decision and feeds the window straight from msg_in.
    w_ptr_nxt    = load ? 4'd0 : (w_scroll_due ? r_ptr + 4'd1 : r_ptr);
    w_src        = load ? msg_in : r_buf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc       <= '0;
      r_counter     <= '0;
      r_frame_cnt   <= '0;
      r_ptr         <= '0;
      r_buf         <= '0;
      r_c0          <= '0;
      r_c1          <= '0;
      r_c2          <= '0;
      r_c3          <= '0;
      r_frame_tick  <= 1'b0;
      r_scroll_tick <= 1'b0;
    end else begin
      r_frame_tick  <= w_boundary;
      r_scroll_tick <= w_scroll_due && !load;
      r_presc       <= w_step ? '0 : r_presc + PW'(1);
      if (w_step)
        r_counter <= r_counter + 4'd1;
      if (load) begin
        r_buf       <= msg_in;
        r_frame_cnt <= '0;
      end else if (w_boundary && scroll_en) begin
        r_frame_cnt <= w_scroll_due ? '0 : r_frame_cnt + FW'(1);
      end
      r_ptr <= w_ptr_nxt;
      if (w_boundary) begin
        r_c3 <= char_at(w_src, w_ptr_nxt);
        r_c2 <= char_at(w_src, w_ptr_nxt + 4'd1);
        r_c1 <= char_at(w_src, w_ptr_nxt + 4'd2);
        r_c0 <= char_at(w_src, w_ptr_nxt + 4'd3);
      end
    end
  end

  assign counter     = r_counter;
  assign c0          = r_c0;
  assign c1          = r_c1;
  assign c2          = r_c2;
  assign c3          = r_c3;
  assign frame_tick  = r_frame_tick;
  assign scroll_tick = r_scroll_tick;

endmodule

// File: tb/tb_display_scan_sequencer.sv
// Directed bench for display_scan_sequencer with PRESCALE=2, SCROLL_REFRESH=2 (32-cycle frames).
// Expected values are hand-derived; e counts clock edges since the last reset release.
module tb_display_scan_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [63:0] msg_in;
  logic        scroll_en;
  logic [3:0]  counter, c0, c1, c2, c3;
  logic        frame_tick, scroll_tick;

  int unsigned total  = 0;
  int unsigned passes = 0;
  int unsigned e      = 0;

  display_scan_sequencer #(.PRESCALE(2), .SCROLL_REFRESH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .msg_in     (msg_in),
    .scroll_en  (scroll_en),
    .counter    (counter),
    .c0         (c0),
    .c1         (c1),
    .c2         (c2),
    .c3         (c3),
    .frame_tick (frame_tick),
    .scroll_tick(scroll_tick)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Window packed as {c3,c2,c1,c0}
  task automatic chk_win(input string tag, input logic [15:0] exp);
    chk(tag, {48'd0, c3, c2, c1, c0}, {48'd0, exp});
  endtask

  // Window for the identity message (char i == i) at pointer p
  function automatic logic [15:0] idwin(input int unsigned p);
    return {4'(p), 4'(p + 1), 4'(p + 2), 4'(p + 3)};
  endfunction

  task automatic next_frame();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (frame_tick === 1'b1) got = 1'b1;
    end
    chk("frame_seen", {63'd0, got}, 64'd1);
    chk("frame_phase", 64'(e % 32), 64'd0);
  endtask

  task automatic to_phase(input int unsigned ph);
    for (int i = 0; i < 40 && (e % 32) != ph; i++) tick();
    chk("phase_reach", 64'(e % 32), 64'(ph));
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; msg_in = '0; scroll_en = 1'b0;
    tick(); tick();
    chk("rst_counter", 64'(counter), 64'd0);
    chk_win("rst_window", 16'h0000);
    chk("rst_ticks", {62'd0, frame_tick, scroll_tick}, 64'd0);
    reset = 1'b0;
    e = 0;

    // 1: scan phases 0,0,1,1,...,15,15,0 with frame_tick on the wrap
    for (int n = 1; n <= 33; n++) begin
      tick();
      chk("scan_counter", 64'(counter), 64'((n / 2) % 16));
      chk("scan_ftick", 64'(frame_tick), 64'(n == 32));
    end

    // 2: load mid-frame with scrolling off
    to_phase(8);
    load = 1'b1; msg_in = 64'hFEDCBA9876543210;
    tick();
    load = 1'b0;
    chk_win("load_hold", 16'h0000);
    next_frame();
    chk_win("load_show", 16'h0123);
    for (int f = 0; f < 5; f++) begin
      next_frame();
      chk_win("noscroll_win", 16'h0123);
      chk("noscroll_stick", 64'(scroll_tick), 64'd0);
    end

    // 3: one scroll step every two frames, full wrap of the buffer
    scroll_en = 1'b1;
    for (int unsigned s = 1; s <= 16; s++) begin
      next_frame();
      chk("scroll_idle", 64'(scroll_tick), 64'd0);
      chk_win("scroll_idle_win", idwin(s - 1));
      next_frame();
      chk("scroll_tick", 64'(scroll_tick), 64'd1);
      chk_win("scroll_win", idwin(s));
    end
    chk_win("scroll_wrap", 16'h0123);

    // 4: freeze with frame_cnt == 1, then resume and step at once
    next_frame();
    chk("pre_freeze", 64'(scroll_tick), 64'd0);
    scroll_en = 1'b0;
    for (int f = 0; f < 3; f++) begin
      next_frame();
      chk_win("freeze_win", 16'h0123);
      chk("freeze_stick", 64'(scroll_tick), 64'd0);
    end
    scroll_en = 1'b1;
    next_frame();
    chk("resume_stick", 64'(scroll_tick), 64'd1);
    chk_win("resume_win", 16'h1234);

    // 5: reach ptr=5 with a scroll due, then load in the boundary cycle
    for (int f = 0; f < 9; f++) next_frame();
    chk_win("ptr5_win", 16'h5678);
    to_phase(31);
    chk("bnd_counter", 64'(counter), 64'd15);
    load = 1'b1; msg_in = 64'h0123456789ABCDEF;
    tick();
    load = 1'b0;
    chk_win("bndload_win", 16'hFEDC);
    chk("bndload_stick", 64'(scroll_tick), 64'd0);
    chk("bndload_ftick", 64'(frame_tick), 64'd1);
    chk("bndload_counter", 64'(counter), 64'd0);
    next_frame();
    chk("post_load_idle", 64'(scroll_tick), 64'd0);
    chk_win("post_load_win", 16'hFEDC);
    next_frame();
    chk("post_load_step", 64'(scroll_tick), 64'd1);
    chk_win("post_load_win1", 16'hEDCB);

    // 6: reset at counter 9 with ptr 7
    for (int f = 0; f < 12; f++) next_frame();
    chk_win("ptr7_win", 16'h8765);
    to_phase(18);
    chk("pre_rst_counter", 64'(counter), 64'd9);
    reset = 1'b1;
    tick();
    chk("midrst_counter", 64'(counter), 64'd0);
    chk_win("midrst_win", 16'h0000);
    chk("midrst_ticks", {62'd0, frame_tick, scroll_tick}, 64'd0);
    reset = 1'b0;
    e = 0;
    tick();
    chk("restart_counter", 64'(counter), 64'd0);
    next_frame();
    chk_win("cleared_win", 16'h0000);
    next_frame();
    chk("cleared_stick", 64'(scroll_tick), 64'd1);
    chk_win("cleared_win1", 16'h0000);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/display_scan_sequencer.md
Name: display_scan_sequencer

Overview:
- Source side of the 4-digit multiplexed display interface.
- Generates the 4-bit scan phase `counter` consumed by the anode driver.
  - Each digit occupies 4 consecutive phases; digit k is lit only in phase 4k+2.
- Supplies the four characters c0..c3 from a 16-character circular message buffer.
- Scrolls the 4-character window through that buffer one position every SCROLL_REFRESH full refresh frames.

Parameters:
- PRESCALE, 16: clk cycles per scan phase step. Legal range ≥1; 1 means the phase advances every cycle.
- SCROLL_REFRESH, 64: full 16-phase frames per scroll step. Legal range ≥1.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- load, input, 1: one-cycle pulse; captures msg_in into the buffer.
- msg_in, input, 64: message. Char i = msg_in[4i+3:4i], i = 0..15; char 0 is shown first.
- scroll_en, input, 1: 1 = scrolling runs; 0 = scroll position and frame count frozen.
- counter, output, 4: scan phase to the anode driver.
- c0, output, 4: character for the rightmost digit (an0).
- c1, output, 4: character for digit an1.
- c2, output, 4: character for digit an2.
- c3, output, 4: character for the leftmost digit (an3).
- frame_tick, output, 1: one-cycle pulse on each counter wrap 15→0.
- scroll_tick, output, 1: one-cycle pulse when the window pointer advances.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - prescaler = 0, counter = 0, frame_cnt = 0, ptr = 0.
  - Buffer = all zero; c0..c3 = 0; frame_tick = 0; scroll_tick = 0.
- Prescaler:
  - Counts 0..PRESCALE-1; step = (prescaler == PRESCALE-1).
  - On step, prescaler → 0 and counter → counter+1 mod 16.
  - Otherwise counter holds.
- Frame boundary:
  - boundary = step && counter == 15; counter becomes 0 that same cycle.
  - frame_tick = 1 for exactly the cycle after the boundary edge (registered).
- Scroll, evaluated only at a boundary:
  - If scroll_en = 1 and frame_cnt == SCROLL_REFRESH-1: frame_cnt → 0, ptr → ptr+1 mod 16, scroll_tick pulses (registered, aligned with frame_tick).
  - Else if scroll_en = 1: frame_cnt increments.
  - If scroll_en = 0: frame_cnt and ptr hold.
- Window, all indices mod 16, wraps seamlessly:
  - At every boundary, c3..c0 are loaded from the buffer at the post-update pointer p (the ptr value after that boundary's scroll decision).
  - c3 = buf[p], c2 = buf[p+1], c1 = buf[p+2], c0 = buf[p+3].
  - c0..c3 change only at boundaries, so a frame never mixes two windows.
- Load:
  - In the load cycle: buffer ← msg_in, ptr → 0, frame_cnt → 0.
  - prescaler and counter are not disturbed.
  - The new window appears at the next boundary.
- Simultaneous events:
  - load in a boundary cycle: load wins; ptr = 0, frame_cnt = 0, no scroll_tick.
  - c0..c3 load buf[0..3] of the new msg_in that same cycle, so the new window is visible right after the edge.
  - reset with load or boundary: reset wins.
- Reset mid-frame:
  - All state returns to reset values next edge; the scan restarts at phase 0.
  - Characters show 0 until the first boundary after a load.
- Latency:
  - counter is registered and moves 1 cycle after its step condition.
  - Ticks are registered, 1 cycle after the boundary edge.
- Widths:
  - prescaler width = max(1, clog2(PRESCALE)).
  - frame_cnt width = max(1, clog2(SCROLL_REFRESH)).
  - All pointer arithmetic is 4-bit natural wrap.

Test Plan:
1. Reset + scan, PRESCALE=2: release reset → counter 0,0,1,1,…,15,15,0. Period 32 clk; frame_tick high the cycle after each 15→0 wrap.
2. Load without scroll, scroll_en=0, msg_in=64'hFEDCBA9876543210 loaded mid-frame:
   - c0..c3 hold 0 until the boundary.
   - Then c3=0, c2=1, c1=2, c0=3, stable across 5 frames; scroll_tick never fires.
3. Scroll, SCROLL_REFRESH=2, scroll_en=1, same message:
   - Every 2nd frame ptr advances; second window c3=1, c2=2, c1=3, c0=4.
   - After 13 steps: c3=D, c2=E, c1=F, c0=0 (wrap).
   - After 16 steps: the window is back to 0,1,2,3.
4. scroll_en toggle: drop scroll_en for 3 frames → window and frame_cnt frozen, no scroll_tick. Re-raise → stepping resumes from the frozen frame_cnt.
5. Load on boundary: pulse load in the cycle counter==15 with step=1 while ptr=5 and scroll due:
   - Result: ptr=0, no scroll_tick.
   - c3..c0 = new msg chars 0..3 immediately after that edge.
6. Reset mid-operation: assert reset at counter=9, ptr=7 → next cycle counter=0, c0..c3=0, ptr=0, ticks 0. Buffer cleared (reload required).
